// File: rtl/dspm_way_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dspm_way_ctrl
// Purpose : Moves data-cache ways between cache mode and scratchpad mode.
//           Locks incoming ways out of the cache, removes outgoing ways from
//           the SPM controller, flushes and zero-fills each affected way, and
//           then commits the new SPM way mask.
// Revision: 1.0 - initial release
// ============================================================================
module dspm_way_ctrl #(
  parameter int NR_WAYS      = 4,
  parameter int LINE_WIDTH   = 128,
  parameter int MEMORY_WIDTH = 172,
  parameter int IDX_WIDTH    = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_valid_i,
  input  logic [NR_WAYS-1:0]            cfg_ways_i,
  output logic                          cfg_ready_o,
  output logic                          done_o,
  output logic [NR_WAYS-1:0]            active_ways_o,
  output logic [NR_WAYS-1:0]            cache_lock_o,
  output logic                          flush_req_o,
  output logic [NR_WAYS-1:0]            flush_way_o,
  input  logic                          flush_ack_i,
  output logic [NR_WAYS-1:0]            mem_req_o,
  output logic [IDX_WIDTH-1:0]          mem_addr_o,
  output logic                          mem_we_o,
  output logic [MEMORY_WIDTH-1:0]       mem_wdata_o,
  output logic [(MEMORY_WIDTH+7)/8-1:0] mem_be_o,
  input  logic                          mem_gnt_i
);

  localparam int OFF       = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W     = IDX_WIDTH - OFF;
  localparam int NUM_LINES = 2 ** CNT_W;

  // The top way can never become scratchpad: the cache always keeps one way.
  localparam logic [NR_WAYS-1:0] SPM_ALLOWED = {1'b0, {(NR_WAYS-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    CLEAR  = 3'd2,
    NEXT   = 3'd3,
    COMMIT = 3'd4
  } state_e;

  state_e             state_q,    state_d;
  logic [NR_WAYS-1:0] tgt_q,      tgt_d;
  logic [NR_WAYS-1:0] to_spm_q,   to_spm_d;
  logic [NR_WAYS-1:0] pend_q,     pend_d;
  logic [NR_WAYS-1:0] active_q,   active_d;
  logic [NR_WAYS-1:0] lock_q,     lock_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;

  logic [NR_WAYS-1:0] clamped;
  logic [NR_WAYS-1:0] acc_to_spm;
  logic [NR_WAYS-1:0] acc_to_cache;
  logic [NR_WAYS-1:0] acc_pend;
  logic [NR_WAYS-1:0] cur_way;
  logic               last_line;

  // One-hot of the lowest set bit; ways are processed lowest index first.
  function automatic logic [NR_WAYS-1:0] lowest_way(input logic [NR_WAYS-1:0] m);
    lowest_way = '0;
    for (int i = NR_WAYS - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_way    = '0;
        lowest_way[i] = 1'b1;
      end
    end
  endfunction

  // Ways entering SPM may hold dirty cache data, so they are flushed first;
  // ways leaving SPM only need zeroing.
  function automatic state_e pick_state(input logic [NR_WAYS-1:0] pend,
                                        input logic [NR_WAYS-1:0] to_spm);
    if (pend == '0) begin
      pick_state = COMMIT;
    end else if ((lowest_way(pend) & to_spm) != '0) begin
      pick_state = FLUSH;
    end else begin
      pick_state = CLEAR;
    end
  endfunction

  assign clamped      = cfg_ways_i & SPM_ALLOWED;
  assign acc_to_spm   = clamped & ~active_q;
  assign acc_to_cache = active_q & ~clamped;
  assign acc_pend     = acc_to_spm | acc_to_cache;
  // pend_q only changes at the end of a way, so this is stable for FLUSH/CLEAR.
  assign cur_way      = lowest_way(pend_q);
  assign last_line    = (line_cnt_q == CNT_W'(NUM_LINES - 1));

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    to_spm_d   = to_spm_q;
    pend_d     = pend_q;
    active_d   = active_q;
    lock_d     = lock_q;
    line_cnt_d = line_cnt_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          tgt_d      = clamped;
          to_spm_d   = acc_to_spm;
          pend_d     = acc_pend;
          // Revoke outgoing ways and lock incoming ways before touching SRAM.
          active_d   = active_q & ~acc_to_cache;
          lock_d     = lock_q | acc_to_spm;
          line_cnt_d = '0;
          state_d    = pick_state(acc_pend, acc_to_spm);
        end
      end
      FLUSH: begin
        if (flush_ack_i) begin
          line_cnt_d = '0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        if (mem_gnt_i) begin
          line_cnt_d = line_cnt_q + CNT_W'(1);
          if (last_line) begin
            pend_d  = pend_q & ~cur_way;
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        line_cnt_d = '0;
        state_d    = pick_state(pend_q, to_spm_q);
      end
      COMMIT: begin
        active_d = tgt_q;
        lock_d   = tgt_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and mask registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      to_spm_q   <= '0;
      pend_q     <= '0;
      active_q   <= '0;
      lock_q     <= '0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      to_spm_q   <= to_spm_d;
      pend_q     <= pend_d;
      active_q   <= active_d;
      lock_q     <= lock_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign cfg_ready_o   = (state_q == IDLE);
  assign done_o        = (state_q == COMMIT);
  assign flush_req_o   = (state_q == FLUSH);
  assign flush_way_o   = (state_q == FLUSH) ? cur_way : '0;
  assign mem_req_o     = (state_q == CLEAR) ? cur_way : '0;
  assign mem_we_o      = (state_q == CLEAR);
  assign mem_addr_o    = {line_cnt_q, {OFF{1'b0}}};
  assign mem_wdata_o   = '0;
  assign mem_be_o      = '1;
  assign active_ways_o = active_q;
  assign cache_lock_o  = lock_q;

  // A way usable by the SPM controller must never be allocatable by the cache.
  a_lock_covers_active: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (active_ways_o & ~cache_lock_o) == '0);

endmodule
`default_nettype wire

// File: tb/tb_dspm_way_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dspm_way_ctrl
// Purpose : Directed self-checking bench for dspm_way_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dspm_way_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic [3:0]   cfg_ways;
  logic         cfg_ready;
  logic         done;
  logic [3:0]   active_ways;
  logic [3:0]   cache_lock;
  logic         flush_req;
  logic [3:0]   flush_way;
  logic         flush_ack;
  logic [3:0]   mem_req;
  logic [11:0]  mem_addr;
  logic         mem_we;
  logic [171:0] mem_wdata;
  logic [21:0]  mem_be;
  logic         mem_gnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  bank;
    logic [11:0] addr;
    logic        we;
    logic        be_ok;
    logic        wd_ok;
  } wr_t;

  wr_t        wr_q[$];
  logic [3:0] fl_q[$];
  int         bank3_cycles = 0;
  int         busy_cycles  = 0;
  int         accepts      = 0;

  dspm_way_ctrl #(
    .NR_WAYS(4), .LINE_WIDTH(128), .MEMORY_WIDTH(172), .IDX_WIDTH(12)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ways_i(cfg_ways), .cfg_ready_o(cfg_ready),
    .done_o(done), .active_ways_o(active_ways), .cache_lock_o(cache_lock),
    .flush_req_o(flush_req), .flush_way_o(flush_way), .flush_ack_i(flush_ack),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_gnt_i(mem_gnt)
  );

  always #5 clk = ~clk;

  // Observe handshakes mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req != 4'b0000 && mem_gnt)
        wr_q.push_back({mem_req, mem_addr, mem_we, (mem_be == '1), (mem_wdata == '0)});
      if (flush_req && flush_ack) fl_q.push_back(flush_way);
      if (mem_req[3]) bank3_cycles++;
      if (mem_req != 4'b0000 || flush_req) busy_cycles++;
      if (cfg_valid && cfg_ready) accepts++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 256 zero-writes to one bank, addresses 0x000..0xFF0 in order.
  task automatic chk_writes(input string tag, input int base, input logic [3:0] bank);
    wr_t e;
    chk({tag, "_nwr_ge"}, 192'(wr_q.size() >= base + 256), 192'(1));
    for (int j = 0; j < 256; j++) begin
      e = (base + j < wr_q.size()) ? wr_q[base + j] : '0;
      chk($sformatf("%s_wr%0d", tag, j), 192'(e), 192'({bank, 12'(j * 16), 3'b111}));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_active"}, 192'(active_ways), 192'(4'b0000));
    chk({tag, "_lock"},   192'(cache_lock),  192'(4'b0000));
    chk({tag, "_done"},   192'(done),        192'(1'b0));
    chk({tag, "_flush"},  192'(flush_req),   192'(1'b0));
    chk({tag, "_memreq"}, 192'(mem_req),     192'(4'b0000));
    chk({tag, "_ready"},  192'(cfg_ready),   192'(1'b1));
  endtask

  // Ticks until done_o is seen; returns the cycle index relative to accept.
  task automatic wait_done(input int start, output int n);
    n = start;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int wb;
    int fb;
    int snap;
    int fr;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ways = 4'b0000;
    flush_ack = 1'b0; mem_gnt = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Test 1: way 0 into SPM, immediate ack and grant.
    wb = wr_q.size(); fb = fl_q.size();
    flush_ack = 1'b1; mem_gnt = 1'b1;
    cfg_valid = 1'b1; cfg_ways = 4'b0001;
    tick();
    cfg_valid = 1'b0;
    chk("t1_lock_t1",   192'(cache_lock),  192'(4'b0001));
    chk("t1_active_t1", 192'(active_ways), 192'(4'b0000));
    chk("t1_flushreq",  192'(flush_req),   192'(1'b1));
    chk("t1_flushway",  192'(flush_way),   192'(4'b0001));
    chk("t1_ready_busy",192'(cfg_ready),   192'(1'b0));
    wait_done(1, n);
    chk("t1_done_cycle", 192'(n), 192'(259));
    tick();
    chk("t1_active_final", 192'(active_ways), 192'(4'b0001));
    chk("t1_lock_final",   192'(cache_lock),  192'(4'b0001));
    chk("t1_done_low",     192'(done),        192'(1'b0));
    chk("t1_nflush", 192'(fl_q.size() - fb), 192'(1));
    chk("t1_flush0", 192'((fl_q.size() > fb) ? fl_q[fb] : 4'b0000), 192'(4'b0001));
    chk("t1_nwr", 192'(wr_q.size() - wb), 192'(256));
    chk_writes("t1", wb, 4'b0001);

    // Test 2: swap SPM from way 0 to way 1.
    wb = wr_q.size(); fb = fl_q.size();
    cfg_valid = 1'b1; cfg_ways = 4'b0010;
    tick();
    cfg_valid = 1'b0;
    chk("t2_active_t1", 192'(active_ways), 192'(4'b0000));
    chk("t2_lock_t1",   192'(cache_lock),  192'(4'b0011));
    chk("t2_memreq_t1", 192'(mem_req),     192'(4'b0001));
    chk("t2_noflush_t1",192'(flush_req),   192'(1'b0));
    wait_done(1, n);
    chk("t2_done_cycle", 192'(n), 192'(516));
    tick();
    chk("t2_active_final", 192'(active_ways), 192'(4'b0010));
    chk("t2_lock_final",   192'(cache_lock),  192'(4'b0010));
    chk("t2_nflush", 192'(fl_q.size() - fb), 192'(1));
    chk("t2_flush0", 192'((fl_q.size() > fb) ? fl_q[fb] : 4'b0000), 192'(4'b0010));
    chk("t2_nwr", 192'(wr_q.size() - wb), 192'(512));
    chk_writes("t2a", wb, 4'b0001);
    chk_writes("t2b", wb + 256, 4'b0010);

    // Test 3: request 1111 is clamped to 0111.
    wb = wr_q.size(); fb = fl_q.size();
    cfg_valid = 1'b1; cfg_ways = 4'b1111;
    tick();
    cfg_valid = 1'b0;
    chk("t3_lock_t1",   192'(cache_lock),  192'(4'b0111));
    chk("t3_active_t1", 192'(active_ways), 192'(4'b0010));
    chk("t3_flushway",  192'(flush_way),   192'(4'b0001));
    wait_done(1, n);
    chk("t3_done_cycle", 192'(n), 192'(517));
    tick();
    chk("t3_active_final", 192'(active_ways), 192'(4'b0111));
    chk("t3_lock_final",   192'(cache_lock),  192'(4'b0111));
    chk("t3_bank3_never",  192'(bank3_cycles), 192'(0));
    chk("t3_nflush", 192'(fl_q.size() - fb), 192'(2));
    chk("t3_flush0", 192'((fl_q.size() > fb) ? fl_q[fb] : 4'b0000), 192'(4'b0001));
    chk("t3_flush1", 192'((fl_q.size() > fb + 1) ? fl_q[fb + 1] : 4'b0000), 192'(4'b0100));
    chk_writes("t3a", wb, 4'b0001);
    chk_writes("t3b", wb + 256, 4'b0100);

    // Test 4: identity request commits without any SRAM or flush traffic.
    snap = busy_cycles;
    cfg_valid = 1'b1; cfg_ways = 4'b1111;
    tick();
    cfg_valid = 1'b0;
    chk("t4_done_t1",  192'(done),      192'(1'b1));
    chk("t4_ready_t1", 192'(cfg_ready), 192'(1'b0));
    tick();
    chk("t4_done_t2",  192'(done),      192'(1'b0));
    chk("t4_ready_t2", 192'(cfg_ready), 192'(1'b1));
    chk("t4_active",   192'(active_ways), 192'(4'b0111));
    chk("t4_no_activity", 192'(busy_cycles - snap), 192'(0));

    // Test 5: reset during CLEAR returns everything to reset values.
    cfg_valid = 1'b1; cfg_ways = 4'b0011;
    tick();
    cfg_valid = 1'b0;
    chk("t5_memreq_t1", 192'(mem_req),     192'(4'b0100));
    chk("t5_active_t1", 192'(active_ways), 192'(4'b0011));
    chk("t5_lock_t1",   192'(cache_lock),  192'(4'b0111));
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk_reset_vals("t5_rst");
    rst_n = 1'b1;
    tick();

    // Test 6: grant gaps, late flush ack, cfg_valid held while busy.
    wb = wr_q.size(); fb = fl_q.size(); snap = accepts;
    flush_ack = 1'b0; mem_gnt = 1'b0;
    cfg_valid = 1'b1; cfg_ways = 4'b0100;
    tick();
    cfg_ways = 4'b0001;
    chk("t6_lock_t1",   192'(cache_lock),  192'(4'b0100));
    chk("t6_active_t1", 192'(active_ways), 192'(4'b0000));
    fr = 0;
    for (int i = 0; i < 10; i++) begin
      if (flush_req && flush_way == 4'b0100) fr++;
      tick();
    end
    chk("t6_flush_held", 192'(fr), 192'(10));
    chk("t6_nflush_before_ack", 192'(fl_q.size() - fb), 192'(0));
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      mem_gnt = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("t6_done_seen", 192'(done), 192'(1'b1));
    cfg_valid = 1'b0;
    mem_gnt = 1'b0;
    tick();
    chk("t6_ready_after", 192'(cfg_ready), 192'(1'b1));
    chk("t6_active_final", 192'(active_ways), 192'(4'b0100));
    chk("t6_lock_final",   192'(cache_lock),  192'(4'b0100));
    chk("t6_one_accept", 192'(accepts - snap), 192'(1));
    chk("t6_nflush", 192'(fl_q.size() - fb), 192'(1));
    chk("t6_nwr", 192'(wr_q.size() - wb), 192'(256));
    chk_writes("t6", wb, 4'b0100);
    tick();
    chk("t6_still_idle", 192'(cfg_ready), 192'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
